pipe_ctrl: RTL and testbench

Pipelined control unit for the rv32 five-stage core. Decodes the instruction in ID into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. Resolves branches in EX, detects load-use and RAW hazards, and drives stall and flush back to the fetch logic. It generalises the single-cycle decoder: field widths are parameterised, stage registers are added, and hazard handling is new.

---
 rtl/pipe_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: rv32 five-stage control pipeline (ID decode, ID/EX, EX/MEM, MEM/WB, branch resolve, hazards).
// Define CTRL_FORWARD_EN for MEM/WB forwarding with load-use stalls only; otherwise full RAW interlock.
module pipe_ctrl #(
    parameter int IMM_SEL_W = 3,
    parameter int ALU_SEL_W = 4,
    parameter int WB_SEL_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_id,
    input  logic                 inst_valid,
    input  logic                 brEq,
    input  logic                 brLT,
    output logic [IMM_SEL_W-1:0] immSel,
    output logic                 ex_aSel,
    output logic                 ex_bSel,
    output logic                 ex_brUn,
    output logic [ALU_SEL_W-1:0] ex_aluSel,
    output logic                 pcSel,
    output logic                 mem_memRW,
    output logic                 mem_memRd,
    output logic                 wb_regWEn,
    output logic [WB_SEL_W-1:0]  wb_wbSel,
    output logic [4:0]           wb_rd,
    output logic [1:0]           fwdA,
    output logic [1:0]           fwdB,
    output logic                 stall,
    output logic                 flush,
    output logic                 illegal
);
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
    localparam logic [IMM_SEL_W-1:0] IMM_I = IMM_SEL_W'(0), IMM_S = IMM_SEL_W'(1),
                                     IMM_B = IMM_SEL_W'(2), IMM_U = IMM_SEL_W'(3), IMM_J = IMM_SEL_W'(4);
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = ALU_SEL_W'(0), ALU_SUB = ALU_SEL_W'(1),
                                     ALU_AND = ALU_SEL_W'(2), ALU_OR = ALU_SEL_W'(3), ALU_XOR = ALU_SEL_W'(4),
                                     ALU_SLL = ALU_SEL_W'(5), ALU_SRL = ALU_SEL_W'(6), ALU_SRA = ALU_SEL_W'(7),
                                     ALU_SLT = ALU_SEL_W'(8), ALU_SLTU = ALU_SEL_W'(9), ALU_PASSB = ALU_SEL_W'(10);
    localparam logic [WB_SEL_W-1:0]  WB_MEM = WB_SEL_W'(0), WB_ALU = WB_SEL_W'(1), WB_PC4 = WB_SEL_W'(2);

    typedef struct packed {
        logic                 valid;
        logic                 illegal;
        logic                 aSel;
        logic                 bSel;
        logic                 brUn;
        logic [ALU_SEL_W-1:0] aluSel;
        logic                 jump;
        logic                 branch;
        logic [2:0]           f3;
        logic                 memRW;
        logic                 memRd;
        logic                 regWEn;
        logic [WB_SEL_W-1:0]  wbSel;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
    } ex_t;

    typedef struct packed {
        logic                valid;
        logic                memRW;
        logic                memRd;
        logic                regWEn;
        logic [WB_SEL_W-1:0] wbSel;
        logic [4:0]          rd;
    } mem_t;

    typedef struct packed {
        logic                valid;
        logic                regWEn;
        logic [WB_SEL_W-1:0] wbSel;
        logic [4:0]          rd;
    } wb_t;

    ex_t  dec, ex_d, ex_q;
    mem_t mem_d, mem_q;
    wb_t  wb_d, wb_q;
    logic legal, use1, use2, taken, hazard;
    logic hit_ex, hit_mem, hit_wb;
    logic [ALU_SEL_W-1:0] alu_f3;
    logic [IMM_SEL_W-1:0] imm_sel;

    // inst_id[5] separates OP from OP-IMM, so SUB is only decoded for register-register ops
    always_comb begin
        alu_f3 = ALU_ADD;
        case (inst_id[14:12])
            3'd0: alu_f3 = (inst_id[5] && inst_id[30]) ? ALU_SUB : ALU_ADD;
            3'd1: alu_f3 = ALU_SLL;
            3'd2: alu_f3 = ALU_SLT;
            3'd3: alu_f3 = ALU_SLTU;
            3'd4: alu_f3 = ALU_XOR;
            3'd5: alu_f3 = inst_id[30] ? ALU_SRA : ALU_SRL;
            3'd6: alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        dec = '0;
        legal = 1'b1;
        use1 = 1'b0;
        use2 = 1'b0;
        imm_sel = IMM_I;
        case (inst_id[6:0])
            OPC_LUI:    begin imm_sel = IMM_U; dec.bSel = 1'b1; dec.aluSel = ALU_PASSB;
                              dec.regWEn = 1'b1; dec.wbSel = WB_ALU; end
            OPC_AUIPC:  begin imm_sel = IMM_U; dec.aSel = 1'b1; dec.bSel = 1'b1;
                              dec.regWEn = 1'b1; dec.wbSel = WB_ALU; end
            OPC_JAL:    begin imm_sel = IMM_J; dec.aSel = 1'b1; dec.bSel = 1'b1; dec.jump = 1'b1;
                              dec.regWEn = 1'b1; dec.wbSel = WB_PC4; end
            OPC_JALR:   begin dec.bSel = 1'b1; dec.jump = 1'b1; dec.regWEn = 1'b1;
                              dec.wbSel = WB_PC4; use1 = 1'b1; end
            OPC_BRANCH: begin imm_sel = IMM_B; dec.aSel = 1'b1; dec.bSel = 1'b1; dec.branch = 1'b1;
                              dec.brUn = inst_id[14] & inst_id[13]; use1 = 1'b1; use2 = 1'b1; end
            OPC_LOAD:   begin dec.bSel = 1'b1; dec.memRd = 1'b1; dec.regWEn = 1'b1;
                              dec.wbSel = WB_MEM; use1 = 1'b1; end
            OPC_STORE:  begin imm_sel = IMM_S; dec.bSel = 1'b1; dec.memRW = 1'b1;
                              use1 = 1'b1; use2 = 1'b1; end
            OPC_OPIMM:  begin dec.bSel = 1'b1; dec.aluSel = alu_f3; dec.regWEn = 1'b1;
                              dec.wbSel = WB_ALU; use1 = 1'b1; end
            OPC_OP:     begin dec.aluSel = alu_f3; dec.regWEn = 1'b1; dec.wbSel = WB_ALU;
                              use1 = 1'b1; use2 = 1'b1; end
            default:    legal = 1'b0;
        endcase
        dec.valid = 1'b1;
        dec.f3    = inst_id[14:12];
        dec.rs1   = inst_id[19:15];
        dec.rs2   = inst_id[24:20];
        dec.rd    = dec.regWEn ? inst_id[11:7] : 5'd0;
        if (!inst_valid || !legal) begin
            dec  = '0;
            use1 = 1'b0;
            use2 = 1'b0;
        end
        dec.illegal = inst_valid & ~legal;
    end

    assign immSel = imm_sel;

    function automatic logic rs_hit(input logic v, input logic wen, input logic [4:0] rd,
                                    input logic u1, input logic [4:0] rs1,
                                    input logic u2, input logic [4:0] rs2);
        return v && wen && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    assign hit_ex  = rs_hit(ex_q.valid,  ex_q.regWEn,  ex_q.rd,  use1, dec.rs1, use2, dec.rs2);
    assign hit_mem = rs_hit(mem_q.valid, mem_q.regWEn, mem_q.rd, use1, dec.rs1, use2, dec.rs2);
    assign hit_wb  = rs_hit(wb_q.valid,  wb_q.regWEn,  wb_q.rd,  use1, dec.rs1, use2, dec.rs2);

`ifdef CTRL_FORWARD_EN
    function automatic logic [1:0] fwd_src(input logic [4:0] rs,
                                           input logic mv, input logic mw, input logic [4:0] mrd,
                                           input logic wv, input logic ww, input logic [4:0] wrd);
        if (mv && mw && mrd != 5'd0 && mrd == rs) return 2'b01;
        if (wv && ww && wrd != 5'd0 && wrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    assign hazard = hit_ex & ex_q.memRd;
    assign fwdA = fwd_src(ex_q.rs1, mem_q.valid, mem_q.regWEn, mem_q.rd, wb_q.valid, wb_q.regWEn, wb_q.rd);
    assign fwdB = fwd_src(ex_q.rs2, mem_q.valid, mem_q.regWEn, mem_q.rd, wb_q.valid, wb_q.regWEn, wb_q.rd);
`else
    // WB is included so a same-cycle regfile write never needs a bypass
    assign hazard = hit_ex | hit_mem | hit_wb;
    assign fwdA = 2'b00;
    assign fwdB = 2'b00;
    logic unused_rs;
    assign unused_rs = ^{ex_q.rs1, ex_q.rs2};
`endif

    logic unused_inst;
    assign unused_inst = ^{inst_id[31], inst_id[29:25]};

    always_comb begin
        taken = 1'b0;
        case (ex_q.f3)
            3'b000:         taken = brEq;
            3'b001:         taken = ~brEq;
            3'b100, 3'b110: taken = brLT;
            3'b101, 3'b111: taken = ~brLT;
            default:        taken = 1'b0;
        endcase
    end

    assign pcSel = ex_q.valid & (ex_q.jump | (ex_q.branch & taken));
    assign flush = pcSel;
    assign stall = hazard & ~flush;

    assign ex_d  = (flush || stall) ? '0 : dec;
    assign mem_d = '{valid: ex_q.valid, memRW: ex_q.memRW, memRd: ex_q.memRd,
                     regWEn: ex_q.regWEn, wbSel: ex_q.wbSel, rd: ex_q.rd};
    assign wb_d  = '{valid: mem_q.valid, regWEn: mem_q.regWEn, wbSel: mem_q.wbSel, rd: mem_q.rd};

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_aSel   = ex_q.aSel;
    assign ex_bSel   = ex_q.bSel;
    assign ex_brUn   = ex_q.brUn;
    assign ex_aluSel = ex_q.aluSel;
    assign illegal   = ex_q.illegal;
    assign mem_memRW = mem_q.valid & mem_q.memRW;
    assign mem_memRd = mem_q.valid & mem_q.memRd;
    assign wb_regWEn = wb_q.valid & wb_q.regWEn;
    assign wb_wbSel  = wb_q.wbSel;
    assign wb_rd     = wb_q.rd;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: instruction-level pipeline model predicts every cycle's outputs.
module tb_pipe_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] inst_id = 32'h0;
    logic        inst_valid = 1'b0, brEq = 1'b0, brLT = 1'b0;
    logic [2:0]  immSel;
    logic        ex_aSel, ex_bSel, ex_brUn;
    logic [3:0]  ex_aluSel;
    logic        pcSel, mem_memRW, mem_memRd, wb_regWEn;
    logic [1:0]  wb_wbSel;
    logic [4:0]  wb_rd;
    logic [1:0]  fwdA, fwdB;
    logic        stall, flush, illegal;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .inst_valid(inst_valid), .brEq(brEq), .brLT(brLT),
        .immSel(immSel), .ex_aSel(ex_aSel), .ex_bSel(ex_bSel), .ex_brUn(ex_brUn), .ex_aluSel(ex_aluSel),
        .pcSel(pcSel), .mem_memRW(mem_memRW), .mem_memRd(mem_memRd), .wb_regWEn(wb_regWEn),
        .wb_wbSel(wb_wbSel), .wb_rd(wb_rd), .fwdA(fwdA), .fwdB(fwdB), .stall(stall), .flush(flush),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum int {K_NONE, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP} kind_e;
    typedef struct {
        bit v; bit ill; kind_e k; bit [2:0] f3; bit f7b; bit [4:0] rd; bit [4:0] rs1; bit [4:0] rs2;
    } rec_t;
    typedef struct { bit [19:0] c; bit [7:0] h; int cyc; } exp_t;

    localparam bit [31:0] NOP = 32'h0000_0013;

    rec_t ex_m, mem_m, wb_m;
    exp_t sb[$];
    int   checks = 0, passed = 0, cyc = 0;
    bit   last_stall = 0, last_flush = 0, kill_next = 0;

    function automatic rec_t blank();
        rec_t r;
        r.v = 0; r.ill = 0; r.k = K_NONE; r.f3 = 0; r.f7b = 0; r.rd = 0; r.rs1 = 0; r.rs2 = 0;
        return r;
    endfunction

    function automatic kind_e kind_of(bit [6:0] opc);
        case (opc)
            7'h37: return K_LUI;   7'h17: return K_AUIPC; 7'h6f: return K_JAL;
            7'h67: return K_JALR;  7'h63: return K_BR;    7'h03: return K_LD;
            7'h23: return K_ST;    7'h13: return K_OPI;   7'h33: return K_OP;
            default: return K_NONE;
        endcase
    endfunction

    function automatic bit writes(kind_e k);
        return k inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LD, K_OPI, K_OP};
    endfunction
    function automatic bit uses1(kind_e k);
        return k inside {K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP};
    endfunction
    function automatic bit uses2(kind_e k);
        return k inside {K_BR, K_ST, K_OP};
    endfunction

    function automatic rec_t decode(bit [31:0] ins, bit vld);
        rec_t r = blank();
        kind_e k = kind_of(ins[6:0]);
        if (!vld) return r;
        if (k == K_NONE) begin r.ill = 1; return r; end
        r.v = 1; r.k = k; r.f3 = ins[14:12]; r.f7b = ins[30];
        r.rd = writes(k) ? ins[11:7] : 5'd0;
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
        return r;
    endfunction

    function automatic bit writer(rec_t r);
        return r.v && writes(r.k) && r.rd != 0;
    endfunction

    function automatic bit hits(rec_t w, rec_t id);
        return writer(w) && id.v && ((uses1(id.k) && id.rs1 == w.rd) || (uses2(id.k) && id.rs2 == w.rd));
    endfunction

    function automatic bit [3:0] alu_of(rec_t r);
        bit [3:0] by_f3 [8];
        by_f3 = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (!r.v) return 4'd0;
        if (r.k == K_LUI) return 4'd10;
        if (r.k != K_OP && r.k != K_OPI) return 4'd0;
        if (r.f3 == 3'd0 && r.k == K_OP && r.f7b) return 4'd1;
        if (r.f3 == 3'd5 && r.f7b) return 4'd7;
        return by_f3[r.f3];
    endfunction

    function automatic bit [2:0] imm_of(kind_e k);
        case (k)
            K_LUI, K_AUIPC: return 3'd3;
            K_JAL:          return 3'd4;
            K_BR:           return 3'd2;
            K_ST:           return 3'd1;
            default:        return 3'd0;
        endcase
    endfunction

    function automatic bit taken(bit [2:0] f3, bit eq, bit lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 0;
        endcase
    endfunction

    function automatic bit [1:0] fwd_of(bit [4:0] rs);
        if (writer(mem_m) && mem_m.rd == rs) return 2'b01;
        if (writer(wb_m) && wb_m.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit [31:0] enc(bit [6:0] opc, bit [4:0] rd, bit [2:0] f3, bit [4:0] rs1,
                                      bit [4:0] rs2, bit [6:0] f7);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    // Drive one cycle, predict its outputs, then advance the model across the edge.
    task automatic step(input bit r, input bit [31:0] ins, input bit v, input bit eq, input bit lt);
        exp_t e;
        rec_t id;
        bit pc, hz, st, a_s, b_s, b_u;
        bit [1:0] fa, fb, ws;
        rst = r; inst_id = ins; inst_valid = v; brEq = eq; brLT = lt;
        id = decode(ins, v);
        pc = ex_m.v && (ex_m.k == K_JAL || ex_m.k == K_JALR || (ex_m.k == K_BR && taken(ex_m.f3, eq, lt)));
`ifdef CTRL_FORWARD_EN
        hz = hits(ex_m, id) && ex_m.k == K_LD;
        fa = fwd_of(ex_m.rs1);
        fb = fwd_of(ex_m.rs2);
`else
        hz = hits(ex_m, id) || hits(mem_m, id) || hits(wb_m, id);
        fa = 2'b00;
        fb = 2'b00;
`endif
        st  = hz && !pc;
        a_s = ex_m.v && (ex_m.k inside {K_AUIPC, K_JAL, K_BR});
        b_s = ex_m.v && ex_m.k != K_OP;
        b_u = ex_m.v && ex_m.k == K_BR && ex_m.f3 >= 3'd6;
        ws  = !(wb_m.v && writes(wb_m.k)) ? 2'd0 : (wb_m.k == K_LD) ? 2'd0 :
              (wb_m.k inside {K_JAL, K_JALR}) ? 2'd2 : 2'd1;
        e.c = {imm_of(kind_of(ins[6:0])), a_s, b_s, b_u, alu_of(ex_m),
               mem_m.v && mem_m.k == K_ST, mem_m.v && mem_m.k == K_LD,
               wb_m.v && writes(wb_m.k), ws, wb_m.rd};
        e.h = {pc, pc, st, ex_m.ill, fa, fb};
        e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            ex_m = blank(); mem_m = blank(); wb_m = blank();
        end else begin
            wb_m = mem_m; mem_m = ex_m; ex_m = (pc || st) ? blank() : id;
        end
        last_stall = st && !r;
        last_flush = pc && !r;
    endtask

    // Fetch-side behaviour: re-present while stalled, kill the slot after a redirect.
    task automatic issue(input bit [31:0] ins, input bit eq, input bit lt);
        int guard = 0;
        if (kill_next) begin
            kill_next = 0;
            step(0, NOP, 0, eq, lt);
        end
        step(0, ins, 1, eq, lt);
        while (last_stall && guard < 8) begin
            step(0, ins, 1, eq, lt);
            guard++;
        end
        kill_next = last_flush;
    endtask

    function automatic bit [31:0] rand_inst();
        bit [6:0] opc;
        case ($urandom_range(0, 13))
            0: opc = 7'h37; 1: opc = 7'h17; 2: opc = 7'h6f; 3: opc = 7'h67;
            4, 5: opc = 7'h63; 6, 7: opc = 7'h03; 8: opc = 7'h23; 9, 10: opc = 7'h13;
            11, 12: opc = 7'h33; default: opc = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h7f;
        endcase
        return enc(opc, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [19:0] ac;
        logic [7:0]  ah;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ac = {immSel, ex_aSel, ex_bSel, ex_brUn, ex_aluSel, mem_memRW, mem_memRd,
                  wb_regWEn, wb_wbSel, wb_rd};
            ah = {pcSel, flush, stall, illegal, fwdA, fwdB};
            checks += 2;
            if (ac === e.c) passed++;
            else $display("FAIL ctrl cyc %0d: got %h expected %h", e.cyc, ac, e.c);
            if (ah === e.h) passed++;
            else $display("FAIL hazard cyc %0d: got %b expected %b", e.cyc, ah, e.h);
        end
    end

    initial begin
        bit eq, lt;
        int sel;
        ex_m = blank(); mem_m = blank(); wb_m = blank();
        @(posedge clk);
        #1;
        step(1, NOP, 1, 0, 0);
        step(1, NOP, 1, 0, 0);
        repeat (4) issue(NOP, 0, 0);
        // load-use
        issue(enc(7'h03, 5, 2, 1, 0, 0), 0, 0);
        issue(enc(7'h33, 6, 0, 5, 2, 0), 0, 0);
        repeat (4) issue(NOP, 0, 0);
        // BEQ taken / not taken
        issue(enc(7'h63, 0, 0, 1, 2, 0), 0, 0);
        issue(NOP, 1, 0);
        repeat (3) issue(NOP, 0, 0);
        issue(enc(7'h63, 0, 0, 1, 2, 0), 0, 0);
        issue(NOP, 0, 0);
        // BLTU taken, BGE not taken
        issue(enc(7'h63, 0, 6, 1, 2, 0), 0, 0);
        issue(NOP, 0, 1);
        issue(enc(7'h63, 0, 5, 1, 2, 0), 0, 0);
        issue(NOP, 0, 1);
        repeat (2) issue(NOP, 0, 0);
        // x0 destination never creates a dependency
        issue(enc(7'h13, 0, 0, 0, 5, 0), 0, 0);
        issue(enc(7'h33, 7, 0, 0, 0, 0), 0, 0);
        repeat (3) issue(NOP, 0, 0);
        // illegal opcode
        issue(enc(7'h00, 9, 0, 1, 2, 0), 0, 0);
        repeat (4) issue(NOP, 0, 0);
        // back-to-back RAW
        issue(enc(7'h13, 3, 0, 0, 1, 0), 0, 0);
        issue(enc(7'h33, 4, 0, 3, 3, 0), 0, 0);
        repeat (4) issue(NOP, 0, 0);
        // reset during a stall, then during a flush
        kill_next = 0;
        step(0, enc(7'h03, 5, 2, 1, 0, 0), 1, 0, 0);
        step(0, enc(7'h33, 6, 0, 5, 2, 0), 1, 0, 0);
        step(1, enc(7'h33, 6, 0, 5, 2, 0), 1, 0, 0);
        step(0, NOP, 1, 0, 0);
        step(0, enc(7'h6f, 1, 0, 0, 0, 0), 1, 0, 0);
        step(0, NOP, 1, 0, 0);
        step(1, NOP, 1, 0, 0);
        step(0, NOP, 1, 0, 0);
        kill_next = 0;
        for (int i = 0; i < 700; i++) begin
            sel = $urandom_range(0, 99);
            eq  = ($urandom_range(0, 1) != 0);
            lt  = ($urandom_range(0, 1) != 0);
            if (sel < 2) begin
                step(1, rand_inst(), 1, eq, lt);
                kill_next = 0;
            end else if (sel < 8) begin
                step(0, rand_inst(), 0, eq, lt);
                kill_next = last_flush;
            end else begin
                issue(rand_inst(), eq, lt);
            end
        end
        repeat (4) issue(NOP, 0, 0);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
